// File: rtl/gelato_pkg.sv
// Shared Gelato SM types: instruction word and default warp count.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif

package gelato_pkg;

  localparam int WARP_NUM_DEF = `WARP_NUM;

  // Decoded instruction as held at the head of a warp's instruction buffer.
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] rd;
    logic [7:0] rs;
    logic [7:0] tag;
  } inst_t;

  localparam int INST_W = $bits(inst_t);

endpackage

// File: rtl/gelato_ibuffer_warpskd_if.sv
// Instruction-buffer to warp-scheduler channel. The buffer side presents a
// valid head per warp; the scheduler pulses caught[w] to pop that head.
interface gelato_ibuffer_warpskd_if
  import gelato_pkg::*;
#(
  parameter int WARP_NUM = WARP_NUM_DEF
);
  logic [WARP_NUM-1:0] valid;
  inst_t               inst [WARP_NUM];
  logic [WARP_NUM-1:0] caught;

  modport master (output valid, output inst, input caught);
  modport slave  (input valid, input inst, output caught);
endinterface

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr,
// wrapping from N-1 back to 0. The pointer register lives in the caller.
module gelato_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  // Scan ptr+1 .. ptr+N (mod N) and keep the first hit.
  always_comb begin
    logic [W:0] w_j;
    logic       w_found;
    w_j     = '0;
    w_found = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int i = 1; i <= N; i++) begin
      w_j = {1'b0, ptr} + (W+1)'(i);
      if (w_j >= (W+1)'(N)) w_j = w_j - (W+1)'(N);
      if (!w_found && req[w_j[W-1:0]]) begin
        w_found = 1'b1;
        gnt_idx = w_j[W-1:0];
      end
    end
    any = en & w_found;
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Warp scheduler: round-robin pick among warps with a valid buffer head and
// spare in-flight credit, pop the winner, and hold it in a one-entry issue
// register toward operand collect. Commits from writeback return credit.
//
// Issue handshake: issue_inst/issue_warp are meaningful while issue_valid=1
// and stay stable until a cycle with issue_valid & issue_ready & rdy, which
// is the transfer. A new grant may load the register in that same cycle.
module gelato_warp_scheduler
  import gelato_pkg::*;
#(
  parameter int WARP_NUM     = WARP_NUM_DEF,
  parameter int MAX_INFLIGHT = 2,
  parameter int WID_W        = $clog2(WARP_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  gelato_ibuffer_warpskd_if.slave      buffer,
  input  logic [WARP_NUM-1:0]          warp_active,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [WID_W-1:0]             issue_warp,
  output inst_t                        issue_inst,
  input  logic                         commit_valid,
  input  logic [WID_W-1:0]             commit_warp,
  output logic                         err_underflow
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic                r_issue_valid;
  logic [WID_W-1:0]    r_issue_warp;
  inst_t               r_issue_inst;
  logic [WID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt [WARP_NUM];
  logic                r_err;

  logic [WARP_NUM-1:0] w_elig;
  logic [WARP_NUM-1:0] w_dec;
  logic [WARP_NUM-1:0] w_gnt;
  logic [WID_W-1:0]    w_gnt_idx;
  logic                w_any;
  logic                w_slot_free;
  logic                w_arb_en;

  // Per-warp eligibility and commit decode.
  always_comb begin
    w_elig = '0;
    w_dec  = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      w_elig[w] = buffer.valid[w] & warp_active[w] &
                  (r_cnt[w] != CNT_W'(MAX_INFLIGHT));
      w_dec[w]  = commit_valid & (commit_warp == WID_W'(w));
    end
  end

  // Grant only when enabled, out of reset, and the issue slot can take it.
  assign w_slot_free = ~r_issue_valid | issue_ready;
  assign w_arb_en    = rdy & ~rst & w_slot_free;

  gelato_rr_arbiter #(
    .N (WARP_NUM),
    .W (WID_W)
  ) u_arb (
    .req     (w_elig),
    .ptr     (r_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign buffer.caught = w_gnt;

  // Issue register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_valid <= 1'b0;
      r_issue_warp  <= '0;
      r_issue_inst  <= '0;
      r_ptr         <= WID_W'(WARP_NUM - 1);
    end else if (rdy) begin
      if (w_any) begin
        r_issue_valid <= 1'b1;
        r_issue_warp  <= w_gnt_idx;
        r_issue_inst  <= buffer.inst[w_gnt_idx];
        r_ptr         <= w_gnt_idx;
      end else if (r_issue_valid && issue_ready) begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  // In-flight credit counters; a grant and a commit to the same warp cancel.
  // A commit that finds the counter at zero raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
      for (int w = 0; w < WARP_NUM; w++) r_cnt[w] <= '0;
    end else if (rdy) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        if (w_dec[w] && (r_cnt[w] == '0)) r_err <= 1'b1;
        if (w_gnt[w] && !w_dec[w]) begin
          r_cnt[w] <= r_cnt[w] + CNT_W'(1);
        end else if (!w_gnt[w] && w_dec[w] && (r_cnt[w] != '0)) begin
          r_cnt[w] <= r_cnt[w] - CNT_W'(1);
        end
      end
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_warp    = r_issue_warp;
  assign issue_inst    = r_issue_inst;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed bench for gelato_warp_scheduler. Stimulus pushes expected caught
// strobes and issue transfers into queues; a negedge monitor pops and checks.
module tb_gelato_warp_scheduler;
  import gelato_pkg::*;

  localparam int NW = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [3:0]  warp_active;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_warp;
  inst_t       issue_inst;
  logic        commit_valid;
  logic [1:0]  commit_warp;
  logic        err_underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int pops [NW];

  logic [3:0]  exp_caught_q[$];
  logic [33:0] exp_issue_q[$];

  gelato_ibuffer_warpskd_if #(.WARP_NUM(NW)) bif ();

  gelato_warp_scheduler #(
    .WARP_NUM     (NW),
    .MAX_INFLIGHT (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .buffer        (bif),
    .warp_active   (warp_active),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_warp    (issue_warp),
    .issue_inst    (issue_inst),
    .commit_valid  (commit_valid),
    .commit_warp   (commit_warp),
    .err_underflow (err_underflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- buffer model: head instruction encodes warp and pop count
  function automatic inst_t make_inst(input int w, input int n);
    inst_t r;
    r.opcode = 8'hA5;
    r.rd     = 8'(w);
    r.rs     = 8'h3C;
    r.tag    = 8'(n);
    return r;
  endfunction

  initial begin
    for (int w = 0; w < NW; w++) pops[w] = 0;
  end

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++)
      if (bif.caught[w]) pops[w] <= pops[w] + 1;
  end

  always_comb begin
    for (int w = 0; w < NW; w++) bif.inst[w] = make_inst(w, pops[w]);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_caught(input int w);
    exp_caught_q.push_back(4'(1 << w));
  endtask

  task automatic push_issue(input int w, input int n);
    exp_issue_q.push_back({2'(w), make_inst(w, n)});
  endtask

  // Monitor: every caught pulse and every issue transfer must match the queue head.
  always @(negedge clk) begin
    logic [3:0]  ec;
    logic [33:0] ei;
    if (|bif.caught) begin
      if (exp_caught_q.size() == 0) begin
        check("caught_unexpected", 64'(bif.caught), 64'(4'b0000));
      end else begin
        ec = exp_caught_q.pop_front();
        check("caught", 64'(bif.caught), 64'(ec));
      end
    end
    if (issue_valid && issue_ready && rdy && !rst) begin
      if (exp_issue_q.size() == 0) begin
        check("issue_unexpected", 64'({issue_warp, issue_inst}), 64'(0));
      end else begin
        ei = exp_issue_q.pop_front();
        check("issue", 64'({issue_warp, issue_inst}), 64'(ei));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input int w);
    commit_valid = 1'b1;
    commit_warp  = 2'(w);
    tick();
    commit_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    rdy          = 1'b1;
    warp_active  = 4'hF;
    issue_ready  = 1'b1;
    commit_valid = 1'b0;
    commit_warp  = 2'd0;
    bif.valid    = 4'h0;

    // Reset values, sampled while reset is held with all warps pending.
    repeat (2) @(posedge clk);
    bif.valid = 4'hF;
    @(negedge clk);
    check("rst_caught", 64'(bif.caught), 64'(4'b0000));
    check("rst_issue_valid", 64'(issue_valid), 64'(1'b0));
    check("rst_issue_warp", 64'(issue_warp), 64'(2'd0));
    check("rst_issue_inst", 64'(issue_inst), 64'(32'h0));
    check("rst_err", 64'(err_underflow), 64'(1'b0));
    bif.valid = 4'h0;
    tick();
    rst = 1'b0;

    // T1: all warps eligible -> caught 0,1,2,3,0; issue one cycle later.
    push_caught(0); push_caught(1); push_caught(2); push_caught(3); push_caught(0);
    push_issue(0, 0); push_issue(1, 0); push_issue(2, 0); push_issue(3, 0); push_issue(0, 1);
    bif.valid = 4'hF;
    @(negedge clk);
    check("t1_valid_at_T", 64'(issue_valid), 64'(1'b0));
    tick();
    @(negedge clk);
    check("t1_valid_at_T1", 64'(issue_valid), 64'(1'b1));
    repeat (4) tick();
    bif.valid = 4'h0;
    tick();
    commit(0); commit(0); commit(1); commit(2); commit(3);

    // T2: only warp 2 -> two back-to-back issues, then blocked by credit.
    push_caught(2); push_caught(2);
    push_issue(2, 1); push_issue(2, 2);
    bif.valid = 4'b0100;
    repeat (4) tick();
    commit_valid = 1'b1;
    commit_warp  = 2'd2;
    @(negedge clk);
    check("t2_no_grant_in_commit_cycle", 64'(bif.caught), 64'(4'b0000));
    tick();
    commit_valid = 1'b0;
    push_caught(2);
    push_issue(2, 3);
    @(negedge clk);
    check("t2_grant_after_commit", 64'(bif.caught), 64'(4'b0100));
    tick();
    bif.valid = 4'h0;
    tick();
    commit(2); commit(2);

    // T3: downstream stall with warp 1 queued.
    issue_ready = 1'b0;
    bif.valid   = 4'b0010;
    push_caught(1);
    push_issue(1, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_caught", 64'(bif.caught), 64'(4'b0000));
      check("t3_stall_inst", 64'(issue_inst), 64'(make_inst(1, 1)));
      check("t3_stall_warp", 64'(issue_warp), 64'(2'd1));
      tick();
    end
    issue_ready = 1'b1;
    push_caught(1);
    push_issue(1, 2);
    @(negedge clk);
    check("t3_same_cycle_grant", 64'(bif.caught), 64'(4'b0010));
    tick();
    bif.valid = 4'h0;
    tick();
    commit(1); commit(1);

    // T4: grant + commit to warp 0 with cnt=1 keeps cnt at 1.
    push_caught(0); push_caught(0); push_caught(0);
    push_issue(0, 2); push_issue(0, 3); push_issue(0, 4);
    bif.valid = 4'b0001;
    tick();
    commit_valid = 1'b1;
    commit_warp  = 2'd0;
    tick();
    commit_valid = 1'b0;
    tick();
    @(negedge clk);
    check("t4_blocked_at_limit_a", 64'(bif.caught), 64'(4'b0000));
    tick();
    @(negedge clk);
    check("t4_blocked_at_limit_b", 64'(bif.caught), 64'(4'b0000));
    tick();
    bif.valid = 4'h0;
    commit(0); commit(0);
    @(negedge clk);
    check("t4_err_clear", 64'(err_underflow), 64'(1'b0));
    commit(3);
    @(negedge clk);
    check("t4_err_set", 64'(err_underflow), 64'(1'b1));
    // cnt[3] must still be 0: exactly two grants before the limit.
    push_caught(3); push_caught(3);
    push_issue(3, 1); push_issue(3, 2);
    bif.valid = 4'b1000;
    repeat (4) tick();
    bif.valid = 4'h0;
    tick();
    commit(3); commit(3);
    @(negedge clk);
    check("t4_err_sticky", 64'(err_underflow), 64'(1'b1));

    // T5: rdy low freezes everything, including commits.
    bif.valid = 4'hF;
    push_caught(0);
    push_issue(0, 5);
    tick();
    rdy          = 1'b0;
    commit_valid = 1'b1;
    commit_warp  = 2'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_frozen_caught", 64'(bif.caught), 64'(4'b0000));
      check("t5_frozen_valid", 64'(issue_valid), 64'(1'b1));
      check("t5_frozen_inst", 64'({issue_warp, issue_inst}), 64'({2'd0, make_inst(0, 5)}));
      tick();
    end
    rdy          = 1'b1;
    commit_valid = 1'b0;
    push_caught(1); push_caught(2); push_caught(3); push_caught(0);
    push_caught(1); push_caught(2); push_caught(3);
    push_issue(1, 3); push_issue(2, 4); push_issue(3, 3); push_issue(0, 6);
    push_issue(1, 4); push_issue(2, 5);
    // The last grant (warp 3, tag 4) is held and then dropped by reset.
    @(negedge clk);
    check("t5_resume_ptr_plus1", 64'(bif.caught), 64'(4'b0010));
    repeat (7) tick();

    // T6: reset with a held issue and nonzero counters.
    issue_ready = 1'b0;
    @(negedge clk);
    check("t6_held_before_rst", 64'(issue_valid), 64'(1'b1));
    check("t6_all_at_limit", 64'(bif.caught), 64'(4'b0000));
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_caught_in_rst", 64'(bif.caught), 64'(4'b0000));
    tick();
    rst = 1'b0;
    push_caught(0);
    push_issue(0, 7);
    @(negedge clk);
    check("t6_valid_dropped", 64'(issue_valid), 64'(1'b0));
    check("t6_err_cleared", 64'(err_underflow), 64'(1'b0));
    check("t6_first_grant_w0", 64'(bif.caught), 64'(4'b0001));
    tick();
    issue_ready = 1'b1;
    push_caught(1); push_caught(2); push_caught(3);
    push_issue(1, 5); push_issue(2, 6); push_issue(3, 5);
    repeat (3) tick();
    bif.valid = 4'h0;
    repeat (3) tick();

    check("end_caught_q_empty", 64'(exp_caught_q.size()), 64'(0));
    check("end_issue_q_empty", 64'(exp_issue_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_warp_scheduler.md
# gelato_warp_scheduler

Consumer end of the instruction-buffer/warp-scheduler channel in each Gelato SM. Each cycle it arbitrates round-robin among warps whose instruction buffer holds a valid head instruction and whose in-flight count is below a limit. It pulses `caught` to pop the winner's buffer and registers the instruction into a single-entry issue stage with a valid/ready handshake toward the operand-collect stage. Per-warp in-flight counters are decremented by commit reports from writeback.

## Interface
Parameters:
- `WARP_NUM`, default `` `WARP_NUM `` (4): warps per SM.
- `MAX_INFLIGHT`, default 2: max issued-but-uncommitted instructions per warp.
- `WID_W`, default `$clog2(WARP_NUM)`: warp index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous and active-high.
- `rdy`  in  1  global enable; low freezes all state.
- `buffer`  `gelato_ibuffer_warpskd_if.slave`  n/a  instruction-buffer channel:
  - `valid[WARP_NUM]` in: buffer head is valid.
  - `inst[WARP_NUM]` in (`inst_t`): head instruction.
  - `caught[WARP_NUM]` out: pop strobe.
- `warp_active`  in  WARP_NUM  per-warp enable mask from the warp controller.
- `issue_valid`  out  1  issue register holds an instruction.
- `issue_ready`  in  1  downstream accepts.
- `issue_warp`  out  WID_W  warp of the issued instruction.
- `issue_inst`  out  `inst_t`  issued instruction.
- `commit_valid`  in  1  one instruction retired.
- `commit_warp`  in  WID_W  warp of the retired instruction.
- `err_underflow`  out  1  sticky; set by a commit to a warp whose count is 0.

## Operation
- Eligibility: `elig[w] = buffer.valid[w] & warp_active[w] & (cnt[w] != MAX_INFLIGHT)`.
- Slot free: `!issue_valid | issue_ready`.
- Grant: when `rdy & slot free & |elig`:
  - Pick the first eligible warp searching from `ptr+1` upward, wrapping at `WARP_NUM-1 → 0`.
  - `buffer.caught[g]` is combinational, one-hot, and asserted in the grant cycle only. All other `caught` bits are 0.
- On a grant edge:
  - `issue_inst <= buffer.inst[g]`, `issue_warp <= g`, `issue_valid <= 1`.
  - `ptr <= g`.
  - `cnt[g]` increments.
- If `issue_valid & issue_ready` and there is no grant: `issue_valid <= 0`. `issue_inst` and `issue_warp` hold their values.
- Counters are `$clog2(MAX_INFLIGHT+1)` bits wide:
  - Grant only: `cnt[g]+1`.
  - Commit only: `cnt[commit_warp]-1`.
  - Grant and commit to the same warp in one cycle: the counter is unchanged.
  - Grant and commit to different warps: each counter updates independently.
- Commit with `cnt==0`: the counter stays 0 and `err_underflow <= 1`.
- Deactivating a warp (`warp_active[w]=0`) only blocks new grants to it. A queued issue and its outstanding commits complete normally.
- `rdy=0`:
  - No grant; all `caught` bits are 0.
  - Registers, counters, `ptr`, and the issue output hold.
  - `issue_valid` stays asserted. A handshake is not accepted while `rdy=0`.
  - `commit_valid` is ignored.

## Timing
- Reset values:
  - `issue_valid=0`, `issue_warp=0`, `issue_inst='0`.
  - `caught` all 0, including during the reset cycle.
  - All `cnt=0`, `err_underflow=0`.
  - `ptr=WARP_NUM-1`, so warp 0 wins first.
- Reset mid-operation drops the held issue and all in-flight counts. Buffer contents are untouched.
- Latency: `buffer.valid` seen in cycle T → `caught` in T, `issue_valid` at T+1.
- Throughput: one issue per cycle while `issue_ready` stays high. Back-to-back grants to the same warp are allowed when it is the only eligible warp.
- Handshake: while `issue_valid & !issue_ready`, `issue_inst` and `issue_warp` stay stable and no grant occurs.

## Structure
- `gelato_pkg` holds `inst_t` and `` `WARP_NUM ``. The interface `gelato_ibuffer_warpskd_if` is defined with the shared interfaces.
- Sub-module `gelato_rr_arbiter`, parameterised on `N`:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt` one-hot, `gnt_idx`, `any`.
  - Purely combinational. The `ptr` register stays in the scheduler.

## Test plan
- Reset, then warps 0–3 all valid and active, `issue_ready=1` → `caught` pulses 0,1,2,3,0 on consecutive cycles; `issue_warp` follows 0,1,2,3 one cycle later.
- Only warp 2 valid, `MAX_INFLIGHT=2`, no commits → two back-to-back issues, then `caught[2]` stays 0. After `commit_valid` with `commit_warp=2`, the next grant occurs in the following cycle.
- `issue_ready=0` for 3 cycles with warp 1 queued → `issue_inst` stable, no `caught` pulses. Raising `issue_ready` gives a grant in the same cycle.
- Grant and commit to warp 0 in the same cycle with `cnt[0]=1` → `cnt[0]` remains 1. A commit to warp 3 with `cnt=0` → `err_underflow=1`, `cnt[3]=0`.
- `rdy=0` for 2 cycles with eligible warps → all `caught` bits 0 and state frozen. Raise `rdy` → the grant resumes at `ptr+1`.
- `rst` asserted while `issue_valid=1` and counters are nonzero → next cycle `issue_valid=0`, all counters 0, and the first grant goes to warp 0.
